// File: rtl/audio_gain_pkg.sv
// Shared definitions for the audio gain pipeline.
// Contents:
//   - default widths;
//   - clog2_min1: index width helper;
//   - unity_coef: the fixed-point value of 1.0 for a given fraction width;
//   - round_sat: signed round-half-up and saturate to a sample width.
package audio_gain_pkg;

    localparam int unsigned DIN_W_DEF     = 24;
    localparam int unsigned COEF_W_DEF    = 10;
    localparam int unsigned FRAC_W_DEF    = 8;
    localparam int unsigned NUM_CH_DEF    = 2;
    localparam int unsigned NUM_STAGE_DEF = 3;

    // Working width of round_sat; the result is returned as {sat, value[RS_W-1:0]}.
    localparam int unsigned RS_W = 64;

    // Bits needed to index n items. Never returns less than 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Coefficient encoding of 1.0.
    function automatic int unsigned unity_coef(input int unsigned frac_w);
        return 32'd1 << frac_w;
    endfunction

    // The low din_w+coef_w bits of prod hold the signed product; the upper bits are ignored.
    // Rounds half toward +inf, drops frac_w bits, then clamps to the signed din_w range.
    // Returns {sat, value}, where value is sign-extended to RS_W bits.
    function automatic logic [RS_W:0] round_sat(
        input logic signed [RS_W-1:0] prod,
        input int unsigned            din_w,
        input int unsigned            coef_w,
        input int unsigned            frac_w
    );
        int unsigned              p_w;
        logic signed [RS_W-1:0]   p_se;
        logic signed [RS_W-1:0]   half;
        logic signed [RS_W-1:0]   r;
        logic signed [RS_W-1:0]   max_v;
        logic signed [RS_W-1:0]   min_v;
        logic [RS_W:0]            res;

        p_w   = din_w + coef_w;
        p_se  = (prod <<< (RS_W - p_w)) >>> (RS_W - p_w);
        half  = (frac_w == 0) ? 64'sd0 : (64'sd1 <<< (frac_w - 1));
        r     = (p_se + half) >>> frac_w;
        max_v = (64'sd1 <<< (din_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (din_w - 1));

        if (r > max_v) begin
            res = {1'b1, max_v};
        end else if (r < min_v) begin
            res = {1'b1, min_v};
        end else begin
            res = {1'b0, r};
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_gain_mul_pipe_round_sat.sv
// audio_round_sat: combinational rounding and saturation of a full-width product.
// Ports:
//   prod   - signed product, DIN_W+COEF_W bits
//   data_c - rounded, saturated sample, DIN_W bits
//   sat_c  - high when clamping was applied
module audio_round_sat
    import audio_gain_pkg::*;
#(
    parameter  int unsigned DIN_W  = DIN_W_DEF,
    parameter  int unsigned COEF_W = COEF_W_DEF,
    parameter  int unsigned FRAC_W = FRAC_W_DEF,
    localparam int unsigned PROD_W = DIN_W + COEF_W
) (
    input  logic [PROD_W-1:0] prod,
    output logic [DIN_W-1:0]  data_c,
    output logic              sat_c
);

    logic [RS_W:0] rs;
    // Redundant sign-extension bits of the clamped value.
    logic          unused_hi;

    always_comb begin
        rs     = round_sat(RS_W'(prod), DIN_W, COEF_W, FRAC_W);
        data_c = rs[DIN_W-1:0];
        sat_c  = rs[RS_W];
    end

    assign unused_hi = ^rs[RS_W-1:DIN_W];

endmodule

// File: rtl/audio_gain_mul_pipe.sv
// audio_gain_mul_pipe: pipelined, multi-channel gain stage.
// Multiplies each signed sample by its channel's signed fixed-point coefficient,
// then rounds and saturates the result back to the sample width.
// Ports:
//   ap_clk, ap_rst                      - clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_chan/s_last - input sample stream
//   coef_wr/coef_chan/coef_data         - shadow coefficient write port
//   m_valid/m_ready/m_data/m_chan/m_last - output sample stream
//   m_sat                               - output beat was clamped
//   sat_clr, sat_count                  - clear and value of the saturated-beat counter
module audio_gain_mul_pipe
    import audio_gain_pkg::*;
#(
    parameter  int unsigned DIN_W     = DIN_W_DEF,
    parameter  int unsigned COEF_W    = COEF_W_DEF,
    parameter  int unsigned FRAC_W    = FRAC_W_DEF,
    parameter  int unsigned NUM_CH    = NUM_CH_DEF,
    parameter  int unsigned NUM_STAGE = NUM_STAGE_DEF,
    localparam int unsigned CH_W      = clog2_min1(NUM_CH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DIN_W-1:0]  s_data,
    input  logic [CH_W-1:0]   s_chan,
    input  logic              s_last,
    input  logic              coef_wr,
    input  logic [CH_W-1:0]   coef_chan,
    input  logic [COEF_W-1:0] coef_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DIN_W-1:0]  m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic              m_last,
    output logic              m_sat,
    input  logic              sat_clr,
    output logic [15:0]       sat_count
);

    localparam int unsigned       PROD_W = DIN_W + COEF_W;
    localparam logic [COEF_W-1:0] UNITY  = COEF_W'(unity_coef(FRAC_W));

    logic              en;
    logic              acc;
    logic [COEF_W-1:0] coef_act [NUM_CH];
    logic [COEF_W-1:0] coef_shd [NUM_CH];
    logic [COEF_W-1:0] coef_sel;
    logic [PROD_W-1:0] prod_in;

    logic              fin_vld;
    logic [PROD_W-1:0] fin_prod;
    logic [CH_W-1:0]   fin_chan;
    logic              fin_last;
    logic [DIN_W-1:0]  rs_data;
    logic              rs_sat;

    // Whole pipeline moves together whenever the output register can be refilled.
    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign acc     = s_valid && en;

    // Active coefficient for the incoming beat; unknown channels get 0.
    always_comb begin
        coef_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(s_chan) == i) begin
                coef_sel = coef_act[i];
            end
        end
    end

    // Shadow bank takes writes; active bank reloads from shadow after an accepted s_last.
    // A write in the commit cycle bypasses the shadow so it is part of that commit.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                coef_act[i] <= UNITY;
                coef_shd[i] <= UNITY;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (coef_wr && (32'(coef_chan) == i)) begin
                    coef_shd[i] <= coef_data;
                end
                if (acc && s_last) begin
                    coef_act[i] <= (coef_wr && (32'(coef_chan) == i)) ? coef_data : coef_shd[i];
                end
            end
        end
    end

    // Full-width signed product of sample and coefficient.
    assign prod_in = $signed({{COEF_W{s_data[DIN_W-1]}}, s_data})
                   * $signed({{DIN_W{coef_sel[COEF_W-1]}}, coef_sel});

    generate
        if (NUM_STAGE == 1) begin : g_single
            // Multiply and round/saturate share the output register.
            assign fin_vld  = acc;
            assign fin_prod = prod_in;
            assign fin_chan = s_chan;
            assign fin_last = s_last;
        end else begin : g_pipe
            localparam int unsigned DEPTH = NUM_STAGE - 1;

            logic              vld_q  [DEPTH];
            logic [PROD_W-1:0] prod_q [DEPTH];
            logic [CH_W-1:0]   chan_q [DEPTH];
            logic              last_q [DEPTH];

            // Stage 0 registers the product; later stages only delay it.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        vld_q[i]  <= 1'b0;
                        prod_q[i] <= '0;
                        chan_q[i] <= '0;
                        last_q[i] <= 1'b0;
                    end
                end else if (en) begin
                    vld_q[0]  <= acc;
                    prod_q[0] <= prod_in;
                    chan_q[0] <= s_chan;
                    last_q[0] <= s_last;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        prod_q[i] <= prod_q[i-1];
                        chan_q[i] <= chan_q[i-1];
                        last_q[i] <= last_q[i-1];
                    end
                end
            end

            assign fin_vld  = vld_q[DEPTH-1];
            assign fin_prod = prod_q[DEPTH-1];
            assign fin_chan = chan_q[DEPTH-1];
            assign fin_last = last_q[DEPTH-1];
        end
    endgenerate

    audio_round_sat #(
        .DIN_W  (DIN_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .prod   (fin_prod),
        .data_c (rs_data),
        .sat_c  (rs_sat)
    );

    // Output register; holds while the consumer stalls.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            m_last  <= 1'b0;
            m_sat   <= 1'b0;
        end else if (en) begin
            m_valid <= fin_vld;
            m_data  <= rs_data;
            m_chan  <= fin_chan;
            m_last  <= fin_last;
            m_sat   <= rs_sat;
        end
    end

    // Counts delivered saturated beats, sticking at all-ones; clear wins.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (m_valid && m_ready && m_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_audio_gain_mul_pipe.sv
// Directed self-checking bench for audio_gain_mul_pipe at default parameters
// (24-bit samples, 10-bit coefficients with 8 fraction bits, 2 channels, 3 stages).
module tb_audio_gain_mul_pipe;

    logic        ap_clk;
    logic        ap_rst;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_chan;
    logic        s_last;
    logic        coef_wr;
    logic        coef_chan;
    logic [9:0]  coef_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_chan;
    logic        m_last;
    logic        m_sat;
    logic        sat_clr;
    logic [15:0] sat_count;

    int total;
    int bad;

    // Stream stimulus and captured output beats.
    logic [23:0] v_data [16];
    logic        v_chan [16];
    logic        v_last [16];
    logic        v_cwr  [16];
    logic        v_cch  [16];
    logic [9:0]  v_cdat [16];
    logic [23:0] o_data [32];
    logic        o_chan [32];
    logic        o_last [32];
    logic        o_sat  [32];
    int          got;
    int          stall_viol;

    audio_gain_mul_pipe #(
        .DIN_W     (24),
        .COEF_W    (10),
        .FRAC_W    (8),
        .NUM_CH    (2),
        .NUM_STAGE (3)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_chan    (s_chan),
        .s_last    (s_last),
        .coef_wr   (coef_wr),
        .coef_chan (coef_chan),
        .coef_data (coef_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_chan    (m_chan),
        .m_last    (m_last),
        .m_sat     (m_sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [23:0] d, input logic c, input logic l);
        v_data[i] = d;
        v_chan[i] = c;
        v_last[i] = l;
        v_cwr[i]  = 1'b0;
        v_cch[i]  = 1'b0;
        v_cdat[i] = 10'h000;
    endtask

    task automatic write_coef(input logic c, input logic [9:0] d);
        coef_wr   = 1'b1;
        coef_chan = c;
        coef_data = d;
        tick();
        coef_wr   = 1'b0;
    endtask

    // Drives n beats from v_*; mode 0 keeps m_ready high, mode 1 uses ready pattern 1,0,0.
    // Records output handshakes and counts any change of the output while stalled.
    task automatic run_stream(input int n, input int mode);
        int          sent;
        int          extra;
        logic        acc;
        logic        hold_v;
        logic [23:0] hold_d;
        logic        hold_c;
        logic        hold_l;
        logic        hold_s;
        sent = 0; extra = 0; got = 0; stall_viol = 0;
        hold_v = 1'b0; hold_d = '0; hold_c = 1'b0; hold_l = 1'b0; hold_s = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (sent < n) begin
                s_valid   = 1'b1;
                s_data    = v_data[sent];
                s_chan    = v_chan[sent];
                s_last    = v_last[sent];
                coef_wr   = v_cwr[sent];
                coef_chan = v_cch[sent];
                coef_data = v_cdat[sent];
            end else begin
                s_valid = 1'b0;
                coef_wr = 1'b0;
            end
            #1;
            if (hold_v && (m_valid !== 1'b1 || m_data !== hold_d || m_chan !== hold_c ||
                           m_last !== hold_l || m_sat !== hold_s)) begin
                stall_viol++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data; hold_c = m_chan; hold_l = m_last; hold_s = m_sat;
            if (m_valid && m_ready) begin
                if (got < 32) begin
                    o_data[got] = m_data;
                    o_chan[got] = m_chan;
                    o_last[got] = m_last;
                    o_sat[got]  = m_sat;
                end
                got++;
            end
            acc = s_valid && s_ready;
            tick();
            if (acc) sent++;
            if (sent == n && got >= n) extra++;
            if (extra > 6) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        coef_wr = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; s_valid = 1'b1; s_data = 24'hABCDEF; s_last = 1'b1; m_ready = 1'b0;
        repeat (3) tick();
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 24'h0) begin bad++; $display("FAIL rst_m_data: got %h want 000000", m_data); end
        total++; if (m_chan !== 1'b0 || m_last !== 1'b0 || m_sat !== 1'b0) begin
            bad++; $display("FAIL rst_tags: got chan=%b last=%b sat=%b want 0 0 0", m_chan, m_last, m_sat);
        end
        total++; if (sat_count !== 16'h0) begin bad++; $display("FAIL rst_sat_count: got %h want 0000", sat_count); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        ap_rst = 1'b0;
        tick();
    endtask

    task automatic test_unity();
        int lat;
        lat = 0;
        m_ready = 1'b1; s_valid = 1'b1; s_data = 24'h123456; s_chan = 1'b0; s_last = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL unity_s_ready: got %b want 1", s_ready); end
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (m_valid === 1'b1) begin
                lat = i;
                break;
            end
            tick();
        end
        total++; if (lat !== 3) begin bad++; $display("FAIL unity_latency: got %0d want 3", lat); end
        total++; if (m_data !== 24'h123456) begin bad++; $display("FAIL unity_data: got %h want 123456", m_data); end
        total++; if (m_sat !== 1'b0 || m_chan !== 1'b0) begin
            bad++; $display("FAIL unity_tags: got sat=%b chan=%b want 0 0", m_sat, m_chan);
        end
        tick();
    endtask

    task automatic test_pos_sat();
        write_coef(1'b1, 10'h1FF);
        set_beat(0, 24'h000000, 1'b0, 1'b1);
        set_beat(1, 24'h600000, 1'b1, 1'b0);
        set_beat(2, 24'hA00000, 1'b1, 1'b0);
        run_stream(3, 0);
        total++; if (got !== 3) begin bad++; $display("FAIL sat_count_beats: got %0d want 3", got); end
        total++; if (o_data[0] !== 24'h0 || o_last[0] !== 1'b1 || o_sat[0] !== 1'b0) begin
            bad++; $display("FAIL sat_commit_beat: got %h last=%b sat=%b want 000000 1 0", o_data[0], o_last[0], o_sat[0]);
        end
        total++; if (o_data[1] !== 24'h7FFFFF || o_sat[1] !== 1'b1 || o_chan[1] !== 1'b1) begin
            bad++; $display("FAIL sat_pos: got %h sat=%b chan=%b want 7fffff 1 1", o_data[1], o_sat[1], o_chan[1]);
        end
        total++; if (o_data[2] !== 24'h800000 || o_sat[2] !== 1'b1) begin
            bad++; $display("FAIL sat_neg: got %h sat=%b want 800000 1", o_data[2], o_sat[2]);
        end
        total++; if (sat_count !== 16'd2) begin bad++; $display("FAIL sat_counter: got %0d want 2", sat_count); end
    endtask

    task automatic test_rounding();
        logic [23:0] exp_d [6];
        exp_d = '{24'h000000, 24'h000002, 24'hFFFFFF, 24'h000001, 24'h000000, 24'h000003};
        write_coef(1'b0, 10'h080);
        set_beat(0, 24'h000000, 1'b0, 1'b1);
        set_beat(1, 24'h000003, 1'b0, 1'b0);
        set_beat(2, 24'hFFFFFD, 1'b0, 1'b0);
        set_beat(3, 24'h000001, 1'b0, 1'b0);
        set_beat(4, 24'hFFFFFF, 1'b0, 1'b0);
        set_beat(5, 24'h000005, 1'b0, 1'b0);
        run_stream(6, 0);
        total++; if (got !== 6) begin bad++; $display("FAIL round_beats: got %0d want 6", got); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (o_data[i] !== exp_d[i] || o_sat[i] !== 1'b0) begin
                bad++; $display("FAIL round_%0d: got %h sat=%b want %h 0", i, o_data[i], o_sat[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_frame_update();
        logic [23:0] exp_d [6];
        logic        exp_c [6];
        logic        exp_l [6];
        exp_d = '{24'h000400, 24'h000400, 24'h000200, 24'h000400, 24'h000400, 24'h000200};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        set_beat(0, 24'h000400, 1'b0, 1'b0);
        run_stream(1, 0);
        total++; if (got !== 1 || o_data[0] !== 24'h000400) begin
            bad++; $display("FAIL frame_first: got n=%0d %h want 1 000400", got, o_data[0]);
        end
        write_coef(1'b0, 10'h080);
        set_beat(0, 24'h000400, 1'b0, 1'b0);
        set_beat(1, 24'h000400, 1'b0, 1'b1);
        set_beat(2, 24'h000400, 1'b0, 1'b0);
        set_beat(3, 24'h000400, 1'b1, 1'b0);
        set_beat(4, 24'h000400, 1'b1, 1'b1);
        v_cwr[4] = 1'b1; v_cch[4] = 1'b1; v_cdat[4] = 10'h080;
        set_beat(5, 24'h000400, 1'b1, 1'b0);
        run_stream(6, 0);
        total++; if (got !== 6) begin bad++; $display("FAIL frame_beats: got %0d want 6", got); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (o_data[i] !== exp_d[i] || o_chan[i] !== exp_c[i] || o_last[i] !== exp_l[i]) begin
                bad++; $display("FAIL frame_%0d: got %h c=%b l=%b want %h c=%b l=%b",
                                i, o_data[i], o_chan[i], o_last[i], exp_d[i], exp_c[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_d [8];
        exp_d = '{24'h000800, 24'h001000, 24'h001800, 24'h002000,
                  24'h002800, 24'h003000, 24'h003800, 24'h004000};
        for (int i = 0; i < 8; i++) begin
            set_beat(i, 24'((i + 1) * 24'h001000), 1'(i % 2), (i == 3) || (i == 7));
        end
        run_stream(8, 1);
        total++; if (got !== 8) begin bad++; $display("FAIL bp_beats: got %0d want 8", got); end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o_data[i] !== exp_d[i] || o_chan[i] !== 1'(i % 2) || o_last[i] !== ((i == 3) || (i == 7))) begin
                bad++; $display("FAIL bp_%0d: got %h c=%b l=%b want %h c=%b l=%b", i, o_data[i],
                                o_chan[i], o_last[i], exp_d[i], 1'(i % 2), (i == 3) || (i == 7));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int cnt;
        cnt = 0;
        write_coef(1'b0, 10'h1FF);
        write_coef(1'b1, 10'h1FF);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 24'h000100; s_chan = 1'b0; s_last = (k == 0);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (m_valid === 1'b1) cnt++;
            tick();
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL midrst_outputs: got %0d want 0", cnt); end
        set_beat(0, 24'h000100, 1'b0, 1'b1);
        set_beat(1, 24'h000100, 1'b0, 1'b0);
        set_beat(2, 24'h000100, 1'b1, 1'b0);
        run_stream(3, 0);
        total++; if (got !== 3) begin bad++; $display("FAIL midrst_beats: got %0d want 3", got); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_data[i] !== 24'h000100) begin
                bad++; $display("FAIL midrst_coef_%0d: got %h want 000100", i, o_data[i]);
            end
        end
        total++; if (sat_count !== 16'h0) begin bad++; $display("FAIL midrst_sat_count: got %h want 0000", sat_count); end
    endtask

    task automatic test_sat_counter();
        int   hs;
        int   sent;
        logic acc;
        logic chk_done;
        hs = 0; sent = 0; chk_done = 1'b0;
        write_coef(1'b1, 10'h1FF);
        set_beat(0, 24'h000000, 1'b1, 1'b1);
        run_stream(1, 0);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        total++; if (sat_count !== 16'h0) begin bad++; $display("FAIL cnt_clear: got %h want 0000", sat_count); end
        s_chan = 1'b1; s_data = 24'h600000; s_last = 1'b0; m_ready = 1'b1;
        for (int cyc = 0; cyc < 70000; cyc++) begin
            s_valid = (sent < 65537);
            #1;
            if (m_valid && m_ready && m_sat) hs++;
            acc = s_valid && s_ready;
            tick();
            if (acc) sent++;
            if (hs == 65534 && !chk_done) begin
                chk_done = 1'b1;
                total++; if (sat_count !== 16'hFFFE) begin bad++; $display("FAIL cnt_fffe: got %h want fffe", sat_count); end
            end
            if (sent == 65537 && !m_valid) break;
        end
        s_valid = 1'b0;
        total++; if (hs !== 65537) begin bad++; $display("FAIL cnt_handshakes: got %0d want 65537", hs); end
        total++; if (sat_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_hold_max: got %h want ffff", sat_count); end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid === 1'b1) break;
            tick();
        end
        total++; if (m_valid !== 1'b1 || m_sat !== 1'b1) begin
            bad++; $display("FAIL cnt_sat_beat: got valid=%b sat=%b want 1 1", m_valid, m_sat);
        end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        total++; if (sat_count !== 16'h0) begin bad++; $display("FAIL cnt_clr_priority: got %h want 0000", sat_count); end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (5) tick();
        total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL cnt_restart: got %h want 0001", sat_count); end
    endtask

    initial begin
        total = 0; bad = 0; got = 0; stall_viol = 0;
        ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_chan = 1'b0; s_last = 1'b0;
        coef_wr = 1'b0; coef_chan = 1'b0; coef_data = '0; m_ready = 1'b0; sat_clr = 1'b0;
        test_reset();
        test_unity();
        test_pos_sat();
        test_rounding();
        test_frame_update();
        test_backpressure();
        test_reset_midstream();
        test_sat_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
